// File: rtl/rgals_pkg.sv
// Shared definitions for the ratiochronous (RGALS) link endpoints.
//   flit_idx_width : width of a flit index counter, never less than 1 bit
//   FlitWidthDefault : default flit width shared with the bisynchronous queues
package rgals_pkg;

  localparam int unsigned FlitWidthDefault = 32;

  // $clog2 collapses to 0 for a count of 1; a counter still needs one bit.
  function automatic int unsigned flit_idx_width(input int unsigned num_flits);
    return (num_flits > 1) ? $clog2(num_flits) : 1;
  endfunction

endpackage

// File: rtl/rgals_msg_out_reg.sv
// Single-entry val/rdy output register.
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   load_i        : capture data_i and mark the entry valid (wins over a drain)
//   data_i        : data to capture
//   ready_i       : downstream ready; a valid entry drains when this is high
//   val_o, data_o : registered entry valid and data
// A load coinciding with a drain replaces the entry, so val_o stays high.
module rgals_msg_out_reg #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             ready_i,
  output logic             val_o,
  output logic [Width-1:0] data_o
);

  logic             val_q, val_d;
  logic [Width-1:0] data_q;

  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = 1'b1;
    end else if (val_q && ready_i) begin
      val_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      val_q  <= 1'b0;
      data_q <= '0;
    end else begin
      val_q <= val_d;
      if (load_i) begin
        data_q <= data_i;
      end
    end
  end

  assign val_o  = val_q;
  assign data_o = data_q;

endmodule

// File: rtl/rgals_flit_deserializer.sv
// Read-end consumer of an RGALS bisynchronous queue: pops p_num_flits narrow
// flits and presents them as one registered wide message.
//   clk, reset_n     : clock and asynchronous active-low reset
//   in_val/in_rdy    : flit handshake with the queue read port
//   in_msg           : flit data (flit 0 lands in the least significant bits)
//   out_val/out_rdy  : message handshake with the downstream block
//   out_msg          : assembled message, registered
//   busy             : a partial message is being built or a message is held
// The last flit is never buffered; it goes straight into the output register
// together with the stored slots, so a message costs N-1 flit registers.
module rgals_flit_deserializer
  import rgals_pkg::*;
#(
  parameter  int unsigned p_flit_width = FlitWidthDefault,
  parameter  int unsigned p_num_flits  = 4,
  localparam int unsigned p_msg_width  = p_flit_width * p_num_flits
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_val,
  output logic                    in_rdy,
  input  logic [p_flit_width-1:0] in_msg,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [p_msg_width-1:0]  out_msg,
  output logic                    busy
);

  localparam int unsigned     CntW     = flit_idx_width(p_num_flits);
  localparam int              NumSlots = int'(p_num_flits) - 1;
  localparam logic [CntW-1:0] LastIdx  = CntW'(p_num_flits - 1);

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [p_flit_width-1:0] slot_q [NumSlots];
  logic                    last_flit;
  logic                    in_go;
  logic                    last_go;
  logic [p_msg_width-1:0]  msg_asm;

  assign last_flit = (cnt_q == LastIdx);
  // Only the last flit can stall: it needs the output register free or draining.
  assign in_rdy    = ~last_flit | ~out_val | out_rdy;
  assign in_go     = in_val & in_rdy;
  assign last_go   = in_go & last_flit;
  assign busy      = (cnt_q != '0) | out_val;

  // Explicit wrap so non-power-of-2 flit counts work.
  always_comb begin
    cnt_d = cnt_q;
    if (in_go) begin
      cnt_d = last_flit ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      for (int i = 0; i < NumSlots; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < NumSlots; i++) begin
        if (in_go && !last_flit && (cnt_q == CntW'(i))) begin
          slot_q[i] <= in_msg;
        end
      end
    end
  end

  // Stored slots plus the live last flit form the complete message.
  always_comb begin
    msg_asm = '0;
    for (int i = 0; i < NumSlots; i++) begin
      msg_asm[i*p_flit_width +: p_flit_width] = slot_q[i];
    end
    msg_asm[NumSlots*p_flit_width +: p_flit_width] = in_msg;
  end

  rgals_msg_out_reg #(
    .Width (p_msg_width)
  ) u_out_reg (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .load_i  (last_go),
    .data_i  (msg_asm),
    .ready_i (out_rdy),
    .val_o   (out_val),
    .data_o  (out_msg)
  );

endmodule

// File: tb/tb_rgals_flit_deserializer.sv
module tb_rgals_flit_deserializer;

  localparam int unsigned FW = 32;
  localparam int unsigned NF = 4;
  localparam int unsigned MW = FW * NF;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_val  = 1'b0;
  logic          in_rdy;
  logic [FW-1:0] in_msg  = '0;
  logic          out_val;
  logic          out_rdy = 1'b0;
  logic [MW-1:0] out_msg;
  logic          busy;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference model: flits collected so far, plus the single held message.
  logic [FW-1:0] m_part [$];
  logic          m_val;
  logic [MW-1:0] m_msg;

  logic pre_rdy_obs;
  logic pre_rdy_exp;
  logic accepted;

  always #5 clk = ~clk;

  rgals_flit_deserializer #(
    .p_flit_width (FW),
    .p_num_flits  (NF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .busy    (busy)
  );

  function automatic logic model_rdy(input logic r);
    return (m_part.size() != NF - 1) || !m_val || r;
  endfunction

  function automatic logic model_busy();
    return (m_part.size() != 0) || m_val;
  endfunction

  task automatic model_reset();
    m_part.delete();
    m_val = 1'b0;
    m_msg = '0;
  endtask

  // Apply inputs for one cycle, sample in_rdy before the edge, advance the
  // model across the edge, and return 1 time unit after it.
  task automatic step(input logic v, input logic [FW-1:0] d, input logic r);
    logic go_in;
    logic go_out;
    in_val  = v;
    in_msg  = d;
    out_rdy = r;
    @(negedge clk);
    pre_rdy_obs = in_rdy;
    pre_rdy_exp = model_rdy(r);
    go_in       = v && pre_rdy_exp;
    go_out      = m_val && r;
    accepted    = go_in;
    @(posedge clk);
    if (go_in) begin
      m_part.push_back(d);
      if (m_part.size() == NF) begin
        for (int k = 0; k < int'(NF); k++) m_msg[k*FW +: FW] = m_part[k];
        m_val = 1'b1;
        m_part.delete();
      end else if (go_out) begin
        m_val = 1'b0;
      end
    end else if (go_out) begin
      m_val = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    reset_n = 1'b0;
    in_val  = 1'b0;
    out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (out_val !== 1'b0) begin n_bad++; $display("FAIL reset_out_val got %b want 0", out_val); end
    n_total++; if (in_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
    n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_total++; if (out_msg !== '0) begin n_bad++; $display("FAIL reset_out_msg got %h want 0", out_msg); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, $urandom, 1'b0);
      n_total++; if (out_val !== 1'b0) begin n_bad++; $display("FAIL post_reset_out_val got %b want 0", out_val); end
    end
    n_total++; if (in_rdy !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_rdy got %b want 1", in_rdy); end
    n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy got %b want 0", busy); end
    n_total++; if (out_msg !== '0) begin n_bad++; $display("FAIL post_reset_out_msg got %h want 0", out_msg); end
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] f [4];
    logic [MW-1:0] exp_msg;
    f[0] = 32'h11111111; f[1] = 32'h22222222; f[2] = 32'h33333333; f[3] = 32'h44444444;
    exp_msg = 128'h44444444_33333333_22222222_11111111;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, f[i], 1'b1);
      n_total++; if (pre_rdy_obs !== 1'b1) begin n_bad++; $display("FAIL b2b_in_rdy flit %0d got %b want 1", i, pre_rdy_obs); end
      n_total++; if (out_val !== (i == 3)) begin n_bad++; $display("FAIL b2b_out_val flit %0d got %b want %b", i, out_val, (i == 3)); end
    end
    n_total++; if (out_msg !== exp_msg) begin n_bad++; $display("FAIL b2b_out_msg got %h want %h", out_msg, exp_msg); end
    step(1'b0, '0, 1'b1);
    n_total++; if (out_val !== 1'b0) begin n_bad++; $display("FAIL b2b_one_cycle got %b want 0", out_val); end
    n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] idx;
    logic [MW-1:0] msg1;
    logic [MW-1:0] msg2;
    msg1 = {32'h4, 32'h3, 32'h2, 32'h1};
    msg2 = {32'h8, 32'h7, 32'h6, 32'h5};
    idx  = 32'h1;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, idx, 1'b0);
      n_total++; if (pre_rdy_obs !== pre_rdy_exp) begin n_bad++; $display("FAIL bp_in_rdy cycle %0d got %b want %b", c, pre_rdy_obs, pre_rdy_exp); end
      if (accepted) idx++;
      if (m_val) begin
        n_total++; if (out_msg !== msg1) begin n_bad++; $display("FAIL bp_hold cycle %0d got %h want %h", c, out_msg, msg1); end
      end
    end
    n_total++; if (in_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_stall_in_rdy got %b want 0", in_rdy); end
    n_total++; if (out_val !== 1'b1) begin n_bad++; $display("FAIL bp_stall_out_val got %b want 1", out_val); end
    step(1'b1, 32'h8, 1'b1);
    n_total++; if (pre_rdy_obs !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_rdy got %b want 1", pre_rdy_obs); end
    n_total++; if (out_val !== 1'b1) begin n_bad++; $display("FAIL bp_replace_out_val got %b want 1", out_val); end
    n_total++; if (out_msg !== msg2) begin n_bad++; $display("FAIL bp_msg2 got %h want %h", out_msg, msg2); end
    step(1'b0, '0, 1'b1);
    n_total++; if (out_val !== 1'b0) begin n_bad++; $display("FAIL bp_drain got %b want 0", out_val); end
    n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_busy got %b want 0", busy); end
  endtask

  task automatic test_bubbles();
    logic [MW-1:0] exp_msg;
    exp_msg = 128'h44444444_33333333_22222222_11111111;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, FW'((i + 1) * 32'h11111111), 1'b1);
      n_total++; if (out_val !== (i == 3)) begin n_bad++; $display("FAIL bub_out_val flit %0d got %b want %b", i, out_val, (i == 3)); end
      if (i < 3) begin
        for (int b = 0; b < 2; b++) begin
          step(1'b0, $urandom, 1'b1);
          n_total++; if (out_val !== 1'b0) begin n_bad++; $display("FAIL bub_gap_out_val got %b want 0", out_val); end
          n_total++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bub_gap_busy got %b want 1", busy); end
        end
      end
    end
    n_total++; if (out_msg !== exp_msg) begin n_bad++; $display("FAIL bub_out_msg got %h want %h", out_msg, exp_msg); end
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_mid_reset();
    logic [MW-1:0] exp_msg;
    exp_msg = {32'h4, 32'h3, 32'h2, 32'h1};
    step(1'b1, 32'hAAAAAAAA, 1'b1);
    step(1'b1, 32'hBBBBBBBB, 1'b1);
    n_total++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mr_busy_before got %b want 1", busy); end
    #1 reset_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mr_busy got %b want 0", busy); end
    n_total++; if (in_rdy !== 1'b1) begin n_bad++; $display("FAIL mr_in_rdy got %b want 1", in_rdy); end
    n_total++; if (out_val !== 1'b0) begin n_bad++; $display("FAIL mr_out_val got %b want 0", out_val); end
    model_reset();
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, FW'(i + 1), 1'b1);
      n_total++; if (out_val !== (i == 3)) begin n_bad++; $display("FAIL mr_out_val flit %0d got %b want %b", i, out_val, (i == 3)); end
    end
    n_total++; if (out_msg !== exp_msg) begin n_bad++; $display("FAIL mr_out_msg got %h want %h", out_msg, exp_msg); end
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, $urandom, 1'b1);
      n_total++; if (pre_rdy_obs !== 1'b1) begin n_bad++; $display("FAIL st_in_rdy flit %0d got %b want 1", i, pre_rdy_obs); end
      n_total++; if (out_val !== ((i % 4) == 3)) begin n_bad++; $display("FAIL st_out_val flit %0d got %b want %b", i, out_val, ((i % 4) == 3)); end
      n_total++; if (out_msg !== m_msg) begin n_bad++; $display("FAIL st_out_msg flit %0d got %h want %h", i, out_msg, m_msg); end
    end
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
      n_total++; if (pre_rdy_obs !== pre_rdy_exp) begin n_bad++; $display("FAIL rnd_in_rdy cycle %0d got %b want %b", c, pre_rdy_obs, pre_rdy_exp); end
      n_total++; if (out_val !== m_val) begin n_bad++; $display("FAIL rnd_out_val cycle %0d got %b want %b", c, out_val, m_val); end
      n_total++; if (busy !== model_busy()) begin n_bad++; $display("FAIL rnd_busy cycle %0d got %b want %b", c, busy, model_busy()); end
      n_total++; if (out_msg !== m_msg) begin n_bad++; $display("FAIL rnd_out_msg cycle %0d got %h want %h", c, out_msg, m_msg); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_bubbles();
    test_mid_reset();
    test_streaming();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
